peripheral_timer_seq: RTL

PERIPHERAL_TIMER_SEQ -- requirements
Module: peripheral_timer_seq

---
 rtl/peripheral_biu_pkg.sv | 20 ++
 rtl/peripheral_timer_pkg.sv | 37 +++
 rtl/peripheral_ahb_single_master.sv | 81 ++++++++
 rtl/peripheral_timer_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/peripheral_biu_pkg.sv
// AHB-Lite bus encodings shared by the peripheral bus-interface blocks.
package peripheral_biu_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/peripheral_timer_pkg.sv
// Timer slave register map and sequencer state encoding.
package peripheral_timer_pkg;

  localparam logic [7:0] OffPrescale = 8'h00;
  localparam logic [7:0] OffIenable  = 8'h0C;
  localparam logic [7:0] OffTimeLo   = 8'h10;
  localparam logic [7:0] OffTimeHi   = 8'h14;
  localparam logic [7:0] OffCmpLo    = 8'h18;
  localparam logic [7:0] OffCmpHi    = 8'h1C;

  typedef logic [3:0] timer_state_t;

  localparam timer_state_t StIdle   = 4'd0;
  localparam timer_state_t StWrPre  = 4'd1;
  localparam timer_state_t StRdTlo  = 4'd2;
  localparam timer_state_t StRdThi  = 4'd3;
  localparam timer_state_t StWrChi  = 4'd4;
  localparam timer_state_t StWrClo  = 4'd5;
  localparam timer_state_t StWrIen  = 4'd6;
  localparam timer_state_t StRun    = 4'd7;
  localparam timer_state_t StDisarm = 4'd8;
  localparam timer_state_t StError  = 4'd9;

  // Successor of a transfer state once its transfer completed cleanly.
  function automatic timer_state_t seq_next(timer_state_t s, logic reload);
    case (s)
      StWrPre: return StRdTlo;
      StRdTlo: return StRdThi;
      StRdThi: return StWrChi;
      StWrChi: return StWrClo;
      StWrClo: return reload ? StRun : StWrIen;
      StWrIen: return StRun;
      default: return StIdle;
    endcase
  endfunction

endpackage

// File: rtl/peripheral_ahb_single_master.sv
// Single, non-pipelined AHB-Lite transfer engine with a req/ack handshake.
module peripheral_ahb_single_master
  import peripheral_biu_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req,
  input  logic [HADDR_SIZE-1:0] addr,
  input  logic                  write,
  input  logic [HDATA_SIZE-1:0] wdata,
  output logic                  ack,
  output logic [HDATA_SIZE-1:0] rdata,
  output logic                  err,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] MIdle = 2'd0;
  localparam logic [1:0] MAddr = 2'd1;
  localparam logic [1:0] MData = 2'd2;

  logic [1:0] mstate;

  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_DATA_PRIV;

  // Returning to MIdle after the data phase yields exactly one IDLE cycle before the next request.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mstate <= MIdle;
      HTRANS <= HTRANS_IDLE;
      HSEL   <= 1'b0;
      HADDR  <= '0;
      HWRITE <= 1'b0;
      HWDATA <= '0;
    end else begin
      unique case (mstate)
        MIdle: begin
          if (req) begin
            mstate <= MAddr;
            HTRANS <= HTRANS_NONSEQ;
            HSEL   <= 1'b1;
            HADDR  <= addr;
            HWRITE <= write;
            HWDATA <= wdata;
          end
        end
        MAddr: begin
          if (HREADY) begin
            mstate <= MData;
            HTRANS <= HTRANS_IDLE;
            HSEL   <= 1'b0;
          end
        end
        MData: begin
          if (HREADY || HRESP == HRESP_ERROR) mstate <= MIdle;
        end
        default: mstate <= MIdle;
      endcase
    end
  end

  // An error response is acted on in its first cycle; the bus is already IDLE in the data phase.
  assign ack   = (mstate == MData) && HREADY && (HRESP == HRESP_OKAY);
  assign err   = (mstate == MData) && (HRESP == HRESP_ERROR);
  assign rdata = HRDATA;

endmodule

// File: rtl/peripheral_timer_seq.sv
// Programs a memory-mapped timer for periodic compare-0 interrupts and reloads it on each match.
module peripheral_timer_seq
  import peripheral_biu_pkg::*;
  import peripheral_timer_pkg::*;
#(
  parameter int                  HADDR_SIZE = 32,
  parameter int                  HDATA_SIZE = 32,
  parameter logic [HADDR_SIZE-1:0] TIMER_BASE = 'h0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [31:0]           cfg_prescale,
  input  logic [63:0]           cfg_period,
  output logic                  busy,
  output logic                  tick,
  output logic [31:0]           tick_cnt,
  output logic                  err,
  input  logic                  tint,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  timer_state_t state_q, state_d;
  logic [31:0]  prescale_q;
  logic [63:0]  period_q;
  logic [63:0]  cmp_q;
  logic [31:0]  time_lo_q;
  logic [31:0]  tick_cnt_q;
  logic         err_q;
  logic         stop_q;
  logic         reload_q;

  logic                  xfer_req;
  logic                  xfer_write;
  logic [7:0]            xfer_off;
  logic [HADDR_SIZE-1:0] xfer_addr;
  logic [HDATA_SIZE-1:0] xfer_wdata;
  logic                  xfer_ack;
  logic                  xfer_err;
  logic [HDATA_SIZE-1:0] xfer_rdata;
  logic                  start_ok;
  logic                  idle_like;

  assign idle_like = (state_q == StIdle) || (state_q == StError);
  // Simultaneous start and stop resolves to stop, which is a no-op when idle.
  assign start_ok  = cfg_start && !cfg_stop;
  assign busy      = !idle_like;
  assign tick_cnt  = tick_cnt_q;
  assign err       = err_q;
  assign xfer_addr = TIMER_BASE + HADDR_SIZE'(xfer_off);

  always_comb begin
    xfer_req   = 1'b1;
    xfer_write = 1'b1;
    xfer_off   = OffPrescale;
    xfer_wdata = '0;
    case (state_q)
      StWrPre:  xfer_wdata = prescale_q;
      StRdTlo:  begin xfer_off = OffTimeLo; xfer_write = 1'b0; end
      StRdThi:  begin xfer_off = OffTimeHi; xfer_write = 1'b0; end
      StWrChi:  begin xfer_off = OffCmpHi;   xfer_wdata = cmp_q[63:32]; end
      StWrClo:  begin xfer_off = OffCmpLo;   xfer_wdata = cmp_q[31:0]; end
      StWrIen:  begin xfer_off = OffIenable; xfer_wdata = 32'd1; end
      StDisarm: xfer_off = OffIenable;
      default:  begin xfer_req = 1'b0; xfer_write = 1'b0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    tick    = 1'b0;
    case (state_q)
      StIdle, StError: if (start_ok) state_d = StWrPre;
      StRun: begin
        if (cfg_stop) begin
          state_d = StDisarm;
        end else if (tint) begin
          state_d = StWrChi;
          tick    = 1'b1;
        end
      end
      StDisarm: begin
        if (xfer_err)      state_d = StError;
        else if (xfer_ack) state_d = StIdle;
      end
      default: begin
        if (xfer_err)                      state_d = StError;
        else if (xfer_ack && (stop_q || cfg_stop)) state_d = StDisarm;
        else if (xfer_ack)                 state_d = seq_next(state_q, reload_q);
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      prescale_q <= '0;
      period_q   <= '0;
      cmp_q      <= '0;
      time_lo_q  <= '0;
      tick_cnt_q <= '0;
      err_q      <= 1'b0;
      stop_q     <= 1'b0;
      reload_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (idle_like && start_ok) begin
        prescale_q <= cfg_prescale;
        period_q   <= (cfg_period == '0) ? 64'd1 : cfg_period;
        tick_cnt_q <= '0;
        err_q      <= 1'b0;
        reload_q   <= 1'b0;
      end
      if (busy && cfg_stop && state_q != StRun && state_q != StDisarm) stop_q <= 1'b1;
      if (state_d == StDisarm || idle_like) stop_q <= 1'b0;
      if (state_q == StRdTlo && xfer_ack) time_lo_q <= xfer_rdata;
      if (state_q == StRdThi && xfer_ack) cmp_q <= {xfer_rdata, time_lo_q} + period_q;
      if (tick) begin
        tick_cnt_q <= tick_cnt_q + 32'd1;
        cmp_q      <= cmp_q + period_q;
        reload_q   <= 1'b1;
      end
      if (xfer_err) err_q <= 1'b1;
    end
  end

  peripheral_ahb_single_master #(
    .HADDR_SIZE (HADDR_SIZE),
    .HDATA_SIZE (HDATA_SIZE)
  ) u_master (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req     (xfer_req),
    .addr    (xfer_addr),
    .write   (xfer_write),
    .wdata   (xfer_wdata),
    .ack     (xfer_ack),
    .rdata   (xfer_rdata),
    .err     (xfer_err),
    .HSEL    (HSEL),
    .HADDR   (HADDR),
    .HWDATA  (HWDATA),
    .HWRITE  (HWRITE),
    .HSIZE   (HSIZE),
    .HBURST  (HBURST),
    .HPROT   (HPROT),
    .HTRANS  (HTRANS),
    .HRDATA  (HRDATA),
    .HREADY  (HREADY),
    .HRESP   (HRESP)
  );

endmodule
